// File: rtl/aes_inv_cipher_ctrl.sv
// AES inverse cipher datapath/control, one round per cycle with round keys fetched by index (optional abort: AES_INV_CIPHER_ABORT_EN).
// Latency: block accepted in cycle T gives out_valid first in cycle T+NR+1.
// Backpressure: result held in DONE until out_ready; in_ready is low whenever busy.
module aes_inv_cipher_ctrl #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] ct_in,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] pt_out,
    output logic         busy
`ifdef AES_INV_CIPHER_ABORT_EN
    ,
    input  logic         abort
`endif
);

    localparam logic [3:0] NR_L = 4'(NR);

    typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_e;

    state_e         state_q, state_d;
    logic [3:0]     rnd_q, rnd_d;
    logic [127:0]   st_q, st_d;
    logic [127:0]   isr_w, isb_w, ark_w, imc_w;
    logic           abort_i;

`ifdef AES_INV_CIPHER_ABORT_EN
    assign abort_i = abort;
`else
    assign abort_i = 1'b0;
`endif

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [3:0][7:0] m9, mb, md, me;
        logic [7:0] a, x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            a     = c[31-8*i -: 8];
            x2    = xt(a);
            x4    = xt(x2);
            x8    = xt(x4);
            m9[i] = x8 ^ a;
            mb[i] = x8 ^ x2 ^ a;
            md[i] = x8 ^ x4 ^ a;
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    // Byte 4c+r is row r of column c; row r rotates right by r columns.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+4-r)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            o[127-32*c -: 32] = inv_mix_col(s[127-32*c -: 32]);
        end
        return o;
    endfunction

    assign isr_w = inv_shift_rows(st_q);

    aes_inv_sbox16 u_inv_sbox (
        .din  (isr_w),
        .dout (isb_w)
    );

    assign ark_w = isb_w ^ rk_in;
    assign imc_w = inv_mix_columns(ark_w);

    always_comb begin
        state_d   = state_q;
        rnd_d     = rnd_q;
        st_d      = st_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        rk_idx    = 4'd0;
        case (state_q)
            IDLE: begin
                busy     = 1'b0;
                in_ready = 1'b1;
                rk_idx   = NR_L;
                if (in_valid && !abort_i) begin
                    st_d    = ct_in ^ rk_in;
                    rnd_d   = NR_L - 4'd1;
                    state_d = (NR == 1) ? FINAL : ROUND;
                end
            end
            ROUND: begin
                rk_idx = rnd_q;
                st_d   = imc_w;
                rnd_d  = rnd_q - 4'd1;
                if (rnd_q == 4'd1) state_d = FINAL;
            end
            FINAL: begin
                st_d    = ark_w;
                state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Abort wins over everything, including a same-cycle acceptance.
        if (abort_i) begin
            state_d = IDLE;
            st_d    = '0;
            rnd_d   = 4'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rnd_q   <= 4'd0;
            st_q    <= '0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            st_q    <= st_d;
        end
    end

    assign pt_out = st_q;

endmodule

// 16-lane combinational inverse S-box: inverse affine map, then GF(2^8) inverse (a^254).
module aes_inv_sbox16 (
    input  logic [127:0] din,
    output logic [127:0] dout
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [7:0] x, s, r;
        x = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
        s = x;
        r = 8'h01;
        for (int i = 0; i < 7; i++) begin
            s = gf_mul(s, s);
            r = gf_mul(r, s);
        end
        return r;
    endfunction

    for (genvar g = 0; g < 16; g++) begin : g_lane
        assign dout[8*g +: 8] = inv_sbox(din[8*g +: 8]);
    end

endmodule

// File: tb/tb_aes_inv_cipher_ctrl.sv
// Bench for aes_inv_cipher_ctrl: forward-AES reference model, vector table and scoreboard,
// plus directed sequences for trace, backpressure, continuous valid, reset and abort.
module tb_aes_inv_cipher_ctrl;

    localparam int NR = 10;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid, in_ready, out_valid, out_ready, busy;
    logic [127:0] ct_in, rk_in, pt_out;
    logic [3:0]   rk_idx;
    logic         abort_s;
`ifdef AES_INV_CIPHER_ABORT_EN
    logic         abort = 1'b0;
    assign abort_s = abort;
`else
    assign abort_s = 1'b0;
`endif

    aes_inv_cipher_ctrl #(.NR(NR)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ct_in     (ct_in),
        .rk_idx    (rk_idx),
        .rk_in     (rk_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pt_out    (pt_out),
        .busy      (busy)
`ifdef AES_INV_CIPHER_ABORT_EN
        ,
        .abort     (abort)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // ---------------- reference model (forward AES-128) ----------------
    logic [7:0]   sbox_t [0:255];
    logic [127:0] rk_tbl [0:10];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] d;
        d = {v, v} << n;
        return d[15:8];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, xb, yb;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            xb  = 8'(x);
            for (int y = 1; y < 256; y++) begin
                yb = 8'(y);
                if (gmul(xb, yb) == 8'h01) inv = yb;
            end
            sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic expand_key(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rcon, 24'h0};
                rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk_tbl[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] enc(input logic [127:0] pt);
        logic [127:0] s, o;
        logic [7:0]   a0, a1, a2, a3;
        s = pt ^ rk_tbl[0];
        for (int r = 1; r <= NR; r++) begin
            for (int i = 0; i < 16; i++) s[127-8*i -: 8] = sbox_t[s[127-8*i -: 8]];
            o = '0;
            for (int c = 0; c < 4; c++)
                for (int rw = 0; rw < 4; rw++)
                    o[127-8*(4*c+rw) -: 8] = s[127-8*(4*((c+rw)%4)+rw) -: 8];
            s = o;
            if (r != NR) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[127-32*c -: 8];
                    a1 = s[119-32*c -: 8];
                    a2 = s[111-32*c -: 8];
                    a3 = s[103-32*c -: 8];
                    s[127-32*c -: 32] = {gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3,
                                         a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3,
                                         a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03),
                                         gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02)};
                end
            end
            s = s ^ rk_tbl[r];
        end
        return s;
    endfunction

    // Round key ROM seen by the DUT; garbage while out_valid so any use in DONE shows up.
    always_comb begin
        rk_in = '0;
        if (out_valid) rk_in = {4{32'hdeadbeef}};
        else if (rk_idx <= 4'd10) rk_in = rk_tbl[rk_idx];
    end

    // ---------------- scoreboard ----------------
    typedef struct { logic [127:0] pt; int acc; } sb_t;
    sb_t          sbq[$];
    int           acc_log[$];
    logic [127:0] drv_pt;
    logic         prev_ov = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            sbq.delete();
            prev_ov <= 1'b0;
        end else begin
            if (in_valid && in_ready && !abort_s) begin
                sbq.push_back('{pt: drv_pt, acc: cyc});
                acc_log.push_back(cyc);
            end
            if (out_valid && !prev_ov) begin
                if (sbq.size() == 0) chk("out_valid_without_block", {127'b0, out_valid}, 128'd0);
                else chk("latency", 128'(cyc - sbq[0].acc), 128'(NR + 1));
            end
            if (out_valid && out_ready && sbq.size() != 0) begin
                chk("pt_out", pt_out, sbq[0].pt);
                void'(sbq.pop_front());
            end
            prev_ov <= out_valid;
        end
    end

    // ---------------- driver helpers ----------------
    task automatic send(input logic [127:0] ct, input logic [127:0] pt, input bit trace);
        int n;
        @(posedge clk); #1;
        ct_in = ct; drv_pt = pt; in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 40) begin @(negedge clk); n++; end
        chk("accept", {127'b0, in_ready}, 128'd1);
        if (trace) chk("rk_idx_accept", 128'(rk_idx), 128'(NR));
        @(posedge clk); #1;
        in_valid = 1'b0;
        ct_in = {$urandom(), $urandom(), $urandom(), $urandom()};
        if (trace) begin
            for (int k = 1; k <= NR; k++) begin
                @(negedge clk);
                chk("rk_idx_trace", 128'(rk_idx), 128'(NR - k));
            end
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while ((busy || sbq.size() != 0) && n < 80) begin @(negedge clk); n++; end
        chk("drain", {127'b0, busy}, 128'd0);
    endtask

    typedef struct { logic [127:0] ct; logic [127:0] pt; } vec_t;
    vec_t vt [6];
    localparam logic [127:0] C1_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT = 128'h00112233445566778899aabbccddeeff;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen, n, s0;
        in_valid = 1'b0; out_ready = 1'b1; ct_in = '0; drv_pt = '0;
        build_sbox();
        expand_key(128'h000102030405060708090a0b0c0d0e0f);
        vt[0] = '{C1_CT, C1_PT};
        vt[1].pt = 128'h0;
        vt[2].pt = {128{1'b1}};
        vt[3].pt = 128'h80000000000000000000000000000001;
        vt[4].pt = 128'h0123456789abcdeffedcba9876543210;
        vt[5].pt = {$urandom(), $urandom(), $urandom(), $urandom()};
        for (int i = 1; i < 6; i++) vt[i].ct = enc(vt[i].pt);

        // reset values
        #1 rst_n = 1'b0;
        #2;
        chk("rst_out_valid", {127'b0, out_valid}, 128'd0);
        chk("rst_in_ready",  {127'b0, in_ready},  128'd1);
        chk("rst_busy",      {127'b0, busy},      128'd0);
        chk("rst_pt_out",    pt_out,              128'd0);
        chk("rst_rk_idx",    128'(rk_idx),        128'(NR));

        // first acceptance on the first edge after release
        in_valid = 1'b1; ct_in = C1_CT; drv_pt = C1_PT;
        #14 rst_n = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; ct_in = {$urandom(), $urandom(), $urandom(), $urandom()};
        chk("first_accept_busy",   {127'b0, busy}, 128'd1);
        chk("first_accept_rk_idx", 128'(rk_idx),   128'(NR - 1));
        wait_idle();

        // vector table; the C.1 entry also checks the rk_idx trace
        for (int i = 0; i < 6; i++) send(vt[i].ct, vt[i].pt, i == 0);
        wait_idle();

        // backpressure: out_ready low for 5 DONE cycles
        @(posedge clk); #1 out_ready = 1'b0;
        send(vt[4].ct, vt[4].pt, 1'b0);
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin @(negedge clk); n++; end
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            chk("bp_out_valid", {127'b0, out_valid}, 128'd1);
            chk("bp_pt_stable", pt_out, vt[4].pt);
            chk("bp_in_ready",  {127'b0, in_ready},  128'd0);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_idle_in_ready",  {127'b0, in_ready},  128'd1);
        chk("bp_idle_out_valid", {127'b0, out_valid}, 128'd0);
        wait_idle();

        // in_valid held high: acceptances exactly 12 cycles apart, ct_in garbage in between
        acc_log.delete();
        @(posedge clk); #1;
        s0 = cyc;
        for (int j = 0; j < 36; j++) begin
            in_valid = 1'b1;
            if (j % 12 == 0) begin
                ct_in = vt[1 + j/12].ct;
                drv_pt = vt[1 + j/12].pt;
            end else begin
                ct_in = {$urandom(), $urandom(), $urandom(), $urandom()};
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        wait_idle();
        chk("cont_accept_count", 128'(acc_log.size()), 128'd3);
        for (int k = 0; k < 3 && k < acc_log.size(); k++)
            chk("cont_accept_cycle", 128'(acc_log[k] - s0), 128'(12 * k));

        // reset pulse in the middle of ROUND (rnd = 5)
        send(vt[2].ct, vt[2].pt, 1'b0);
        n = 0;
        @(negedge clk);
        while (rk_idx != 4'd5 && n < 20) begin @(negedge clk); n++; end
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", {127'b0, out_valid}, 128'd0);
        chk("mid_rst_in_ready",  {127'b0, in_ready},  128'd1);
        chk("mid_rst_busy",      {127'b0, busy},      128'd0);
        chk("mid_rst_pt_out",    pt_out,              128'd0);
        chk("mid_rst_rk_idx",    128'(rk_idx),        128'(NR));
        @(posedge clk);
        @(negedge clk); #1 rst_n = 1'b1;
        seen = 0;
        repeat (15) begin @(negedge clk); if (out_valid) seen++; end
        chk("mid_rst_no_out_valid", 128'(seen), 128'd0);
        send(C1_CT, C1_PT, 1'b0);
        wait_idle();

`ifdef AES_INV_CIPHER_ABORT_EN
        // abort during FINAL: block discarded, state cleared
        send(C1_CT, C1_PT, 1'b0);
        n = 0;
        @(negedge clk);
        while (!(rk_idx == 4'd0 && busy && !out_valid) && n < 20) begin @(negedge clk); n++; end
        #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        sbq.delete();
        @(negedge clk);
        chk("abort_busy",   {127'b0, busy}, 128'd0);
        chk("abort_pt_out", pt_out,         128'd0);
        seen = 0;
        repeat (12) begin @(negedge clk); if (out_valid) seen++; end
        chk("abort_no_out_valid", 128'(seen), 128'd0);
        send(C1_CT, C1_PT, 1'b0);
        wait_idle();
`endif

        chk("sb_empty", 128'(sbq.size()), 128'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
